// File: rtl/pio_in_poller_if.sv
// Bus bundle for the PIO poller: PIO-facing read master plus CPU-facing register slave and irq.
// The poller takes the slave modport; the surrounding system (CPU side and PIO side) takes master.
interface pio_in_poller_if;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;

    modport slave (
        output m_address, m_read,
        input  m_readdata,
        input  s_address, s_read, s_write, s_writedata,
        output s_readdata, irq
    );

    modport master (
        input  m_address, m_read,
        output m_readdata,
        output s_address, s_read, s_write, s_writedata,
        input  s_readdata, irq
    );
endinterface

// File: rtl/pio_in_poller.sv
// Polls PIO data register 0 every PERIOD+3 cycles and queues timestamped change events for the CPU.
// CPU reads have 1-cycle latency; a full FIFO drops new events and sets a sticky overflow flag.
module pio_in_poller #(
    parameter int DATA_W     = 16,
    parameter int PERIOD_W   = 16,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    pio_in_poller_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + TS_W;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READ, ST_CAPTURE} state_t;
    state_t state, state_nxt;

    logic                enable, irq_en, irq_en_nxt;
    logic [PERIOD_W-1:0] period, cnt;
    logic [TS_W-1:0]     ts;
    logic [DATA_W-1:0]   base, sample;
    logic                base_vld;
    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count, count_nxt;
    logic                ovf, empty, full;
    logic                cap, push, pop, do_push, ovf_set;
    logic                wr_ctrl, wr_period, wr_status;
    logic [31:0]         rd_mux;
    logic                unused_bits;

    assign unused_bits = ^{bus.m_readdata, bus.s_writedata};

    assign sample    = bus.m_readdata[DATA_W-1:0];
    assign wr_ctrl   = bus.s_write && (bus.s_address == 2'd0);
    assign wr_period = bus.s_write && (bus.s_address == 2'd1);
    assign wr_status = bus.s_write && (bus.s_address == 2'd2);

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    // A capture in a cycle where enable has already dropped is thrown away.
    assign cap     = (state == ST_CAPTURE) && enable;
    assign push    = cap && base_vld && (sample != base);
    assign pop     = bus.s_read && (bus.s_address == 2'd3) && !empty;
    assign do_push = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    assign count_nxt  = count + CW'(do_push) - CW'(pop);
    assign irq_en_nxt = wr_ctrl ? bus.s_writedata[1] : irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (enable) state_nxt = ST_WAIT;
            ST_WAIT:    if (cnt == '0) state_nxt = ST_READ;
            ST_READ:    state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_WAIT;
            default:    state_nxt = ST_IDLE;
        endcase
        if (!enable) state_nxt = ST_IDLE;
    end

    always_comb begin
        bus.m_read = (state == ST_READ);
    end

    assign bus.m_address = 2'd0;

    // PERIOD is sampled only when entering WAIT, so mid-wait writes apply to the next interval.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state_nxt == ST_WAIT && state != ST_WAIT) begin
            cnt <= period;
        end else if (state == ST_WAIT && cnt != '0) begin
            cnt <= cnt - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts       <= '0;
            base     <= '0;
            base_vld <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (state == ST_IDLE) begin
                base_vld <= 1'b0;
            end else if (cap) begin
                base     <= sample;
                base_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b0;
            irq_en <= 1'b0;
            period <= '1;
            ovf    <= 1'b0;
        end else begin
            if (wr_ctrl) enable <= bus.s_writedata[0];
            irq_en <= irq_en_nxt;
            if (wr_period) period <= bus.s_writedata[PERIOD_W-1:0];
            if (ovf_set)                            ovf <= 1'b1;
            else if (wr_status && bus.s_writedata[8]) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {ts, sample};
    end

    always_comb begin
        rd_mux = '0;
        case (bus.s_address)
            2'd0: rd_mux = {30'd0, irq_en, enable};
            2'd1: rd_mux = 32'(period);
            2'd2: rd_mux = {22'd0, empty, ovf, 8'(count)};
            2'd3: rd_mux = empty ? 32'd0 : 32'(mem[rd_ptr]);
            default: rd_mux = '0;
        endcase
    end

    // irq is registered from next-state values so it lands on the same edge as the push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.s_readdata <= '0;
            bus.irq        <= 1'b0;
        end else begin
            if (bus.s_read) bus.s_readdata <= rd_mux;
            bus.irq <= irq_en_nxt && (count_nxt != '0);
        end
    end
endmodule

// File: tb/tb_pio_in_poller.sv
// Bench for pio_in_poller: directed scenarios with literal expectations, then a randomized run,
// all cross-checked each cycle against a schedule/queue model of the poller.
module tb_pio_in_poller;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pio_val = 16'h00A5;
    int          checks = 0;
    int          errors = 0;

    pio_in_poller_if bus();
    pio_in_poller dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // PIO slave: data valid the cycle after m_read, garbage otherwise.
    always @(posedge clk) begin
        if (bus.m_read) bus.m_readdata <= {16'($urandom), pio_val};
        else            bus.m_readdata <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle index since reset, read/capture schedule, event queue.
    int          cyc, m_next_rd, m_cap;
    bit          m_en, m_ien, m_ovf, m_bvld, m_irq, m_mread, m_push, m_pop, m_oset;
    logic [15:0] m_per, m_base, m_samp;
    logic [31:0] m_q[$];
    logic [31:0] m_rdata, m_ent;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; m_next_rd = -1; m_cap = -1;
            m_en = 0; m_ien = 0; m_ovf = 0; m_bvld = 0; m_irq = 0; m_mread = 0;
            m_per = 16'hFFFF; m_base = 0; m_samp = 0; m_rdata = 0;
            m_q.delete();
        end else begin
            m_push = 0; m_oset = 0; m_ent = 0;
            if (bus.s_read) begin
                case (bus.s_address)
                    2'd0: m_rdata = {30'd0, m_ien, m_en};
                    2'd1: m_rdata = {16'd0, m_per};
                    2'd2: m_rdata = {22'd0, m_q.size() == 0, m_ovf, 8'(m_q.size())};
                    default: m_rdata = (m_q.size() != 0) ? m_q[0] : 32'd0;
                endcase
            end
            m_pop = bus.s_read && bus.s_address == 2'd3 && m_q.size() != 0;
            if (!m_en) begin
                m_next_rd = -1; m_cap = -1; m_bvld = 0;
            end else if (cyc == m_cap) begin
                if (m_bvld && m_samp != m_base) begin
                    m_push = 1; m_ent = {16'(cyc), m_samp};
                end
                m_base = m_samp; m_bvld = 1;
                m_cap = -1; m_next_rd = cyc + int'(m_per) + 2;
            end else if (cyc == m_next_rd) begin
                m_samp = pio_val; m_cap = cyc + 1; m_next_rd = -1;
            end else if (m_next_rd < 0 && m_cap < 0) begin
                m_next_rd = cyc + int'(m_per) + 2;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() == DEPTH) m_oset = 1;
                else m_q.push_back(m_ent);
            end
            if (bus.s_write) begin
                case (bus.s_address)
                    2'd0: begin m_en = bus.s_writedata[0]; m_ien = bus.s_writedata[1]; end
                    2'd1: m_per = bus.s_writedata[15:0];
                    2'd2: if (bus.s_writedata[8]) m_ovf = 0;
                    default: ;
                endcase
            end
            if (m_oset) m_ovf = 1;
            m_irq = m_ien && m_q.size() != 0;
            cyc++;
            m_mread = (cyc == m_next_rd);
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_read", 32'(bus.m_read), 32'(m_mread));
            chk("irq", 32'(bus.irq), 32'(m_irq));
            chk("s_readdata", bus.s_readdata, m_rdata);
            chk("m_address", 32'(bus.m_address), 32'd0);
        end
    end

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk); bus.s_address = a; bus.s_read = 1'b1;
        @(negedge clk); bus.s_read = 1'b0; d = bus.s_readdata;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk); bus.s_address = a; bus.s_writedata = v; bus.s_write = 1'b1;
        @(negedge clk); bus.s_write = 1'b0;
    endtask

    task automatic wait_mread(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.m_read) return;
        end
        errors++; checks++;
        $display("FAIL wait_mread actual=timeout required=m_read within %0d cycles", budget);
    endtask

    task automatic wait_cap(input int budget);
        wait_mread(budget);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int k;
        logic [15:0] ovf_vals [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        logic [15:0] drain [4]    = '{16'h6001, 16'h6002, 16'h6003, 16'h7777};

        bus.s_address = 0; bus.s_read = 0; bus.s_write = 0; bus.s_writedata = 0;
        repeat (3) @(negedge clk);
        chk("rst_m_read", 32'(bus.m_read), 32'd0);
        chk("rst_irq", 32'(bus.irq), 32'd0);
        chk("rst_s_readdata", bus.s_readdata, 32'd0);
        reset_n = 1'b1;

        cpu_read(2'd0, d); chk("rst_ctrl", d, 32'd0);
        cpu_read(2'd1, d); chk("rst_period", d, 32'h0000FFFF);
        cpu_read(2'd2, d); chk("rst_status", d, 32'h00000200);
        cpu_read(2'd3, d); chk("empty_event", d, 32'd0);

        // Baseline only: constant input, fixed poll interval.
        cpu_write(2'd1, 32'd4);
        cpu_write(2'd0, 32'd1);
        wait_mread(60);
        for (int r = 0; r < 2; r++) begin
            k = 0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (bus.m_read) begin k = i; break; end
            end
            chk("poll_interval", 32'(k), 32'd7);
        end
        cpu_read(2'd2, d); chk("baseline_status", d, 32'h200);

        // Single change.
        cpu_write(2'd0, 32'd3);
        pio_val = 16'h1234;
        wait_cap(20);
        chk("irq_after_push", 32'(bus.irq), 32'd1);
        cpu_read(2'd2, d); chk("status_one", d, 32'h001);
        cpu_read(2'd3, d); chk("event_data", {16'd0, d[15:0]}, 32'h1234);
        cpu_read(2'd2, d); chk("status_drained", d, 32'h200);
        chk("irq_drained", 32'(bus.irq), 32'd0);

        // Overflow with five unread changes.
        for (int i = 0; i < 5; i++) begin
            pio_val = ovf_vals[i];
            wait_cap(20);
        end
        cpu_read(2'd2, d); chk("status_ovf", d, 32'h104);
        cpu_write(2'd2, 32'h100);
        cpu_read(2'd2, d); chk("status_ovf_clr", d, 32'h004);
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'd3, d); chk("ovf_pop_order", {16'd0, d[15:0]}, {16'd0, ovf_vals[i]});
        end
        cpu_read(2'd2, d); chk("status_after_pops", d, 32'h200);

        // Pop from a full FIFO on the push edge.
        for (int i = 0; i < 4; i++) begin
            pio_val = 16'(16'h6000 + i);
            wait_cap(20);
        end
        cpu_read(2'd2, d); chk("status_full", d, 32'h004);
        pio_val = 16'h7777;
        wait_mread(20);
        @(negedge clk); bus.s_address = 2'd3; bus.s_read = 1'b1;
        @(negedge clk); bus.s_read = 1'b0;
        chk("simul_pop_data", {16'd0, bus.s_readdata[15:0]}, 32'h6000);
        cpu_read(2'd2, d); chk("simul_status", d, 32'h004);
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'd3, d); chk("simul_drain", {16'd0, d[15:0]}, {16'd0, drain[i]});
        end

        // Disable in the READ cycle.
        pio_val = 16'hAAAA;
        wait_mread(20);
        bus.s_address = 2'd0; bus.s_writedata = 32'h2; bus.s_write = 1'b1;
        @(negedge clk); bus.s_write = 1'b0;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.m_read) k++;
        end
        chk("disabled_reads", 32'(k), 32'd0);
        cpu_read(2'd2, d); chk("disable_no_push", d, 32'h200);
        pio_val = 16'hBBBB;
        cpu_write(2'd0, 32'd3);
        wait_cap(20);
        cpu_read(2'd2, d); chk("reenable_baseline", d, 32'h200);
        pio_val = 16'hCCCC; wait_cap(20);
        pio_val = 16'hDDDD; wait_cap(20);
        cpu_read(2'd2, d); chk("two_queued", d, 32'h002);

        // Asynchronous reset while m_read is high with events pending.
        wait_mread(20);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_m_read", 32'(bus.m_read), 32'd0);
        chk("arst_irq", 32'(bus.irq), 32'd0);
        chk("arst_s_readdata", bus.s_readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cpu_read(2'd1, d); chk("post_rst_period", d, 32'h0000FFFF);
        cpu_read(2'd2, d); chk("post_rst_status", d, 32'h200);

        // Randomized traffic.
        cpu_write(2'd1, 32'($urandom_range(0, 5)));
        cpu_write(2'd0, 32'd3);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus.s_read    = ($urandom_range(0, 99) < 25);
            bus.s_write   = ($urandom_range(0, 99) < 6);
            bus.s_address = 2'($urandom_range(0, 3));
            case (bus.s_address)
                2'd0:    bus.s_writedata = {30'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 85)};
                2'd1:    bus.s_writedata = 32'($urandom_range(0, 5));
                default: bus.s_writedata = $urandom;
            endcase
            if ($urandom_range(0, 99) < 20) pio_val = 16'($urandom_range(0, 3));
        end
        @(negedge clk); bus.s_read = 1'b0; bus.s_write = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
